// File: rtl/complex_alu_seq.sv
// Sequential complex-number ALU: add, sub, multiply and magnitude-squared on
// packed {real, imag} operands with a valid/ready handshake on both sides.
module complex_alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [1:0]   control,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int W = N / 2;
  localparam int A = 2 * W + 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAG = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic signed [W-1:0]  xr_q, xr_d, xi_q, xi_d, yr_q, yr_d, yi_q, yi_d;
  logic signed [A-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [N-1:0]         result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 alive_q;

  logic signed [W-1:0]   ma, mb;
  logic signed [2*W-1:0] ma_ext, mb_ext, prod;
  logic signed [A-1:0]   prod_ext;
  logic signed [A-1:0]   xr_ext, xi_ext, yr_ext, yi_ext;
  logic [1:0]            k_last;

  // A value fits in W signed bits iff all bits from W-1 upward agree.
  function automatic logic out_of_range(input logic signed [A-1:0] v);
    logic [A-W:0] top;
    top = v[A-1:W-1];
    return !((&top) || !(|top));
  endfunction

  assign in_ready  = alive_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

  assign xr_ext = {{(A-W){xr_q[W-1]}}, xr_q};
  assign xi_ext = {{(A-W){xi_q[W-1]}}, xi_q};
  assign yr_ext = {{(A-W){yr_q[W-1]}}, yr_q};
  assign yi_ext = {{(A-W){yi_q[W-1]}}, yi_q};

  // The single shared multiplier sees one operand pair per CALC cycle.
  always_comb begin
    ma = xr_q;
    mb = yr_q;
    case (op_q)
      OP_MUL: begin
        case (cnt_q)
          2'd0:    begin ma = xr_q; mb = yr_q; end
          2'd1:    begin ma = xi_q; mb = yi_q; end
          2'd2:    begin ma = xr_q; mb = yi_q; end
          default: begin ma = xi_q; mb = yr_q; end
        endcase
      end
      OP_MAG: begin
        if (cnt_q == 2'd0) begin
          ma = xr_q; mb = xr_q;
        end else begin
          ma = xi_q; mb = xi_q;
        end
      end
      default: begin
        ma = xr_q;
        mb = yr_q;
      end
    endcase
  end

  assign ma_ext   = {{W{ma[W-1]}}, ma};
  assign mb_ext   = {{W{mb[W-1]}}, mb};
  assign prod     = ma_ext * mb_ext;
  assign prod_ext = {{2{prod[2*W-1]}}, prod};

  always_comb begin
    case (op_q)
      OP_MUL:  k_last = 2'd3;
      OP_MAG:  k_last = 2'd1;
      default: k_last = 2'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    xr_d     = xr_q;
    xi_d     = xi_q;
    yr_d     = yr_q;
    yi_d     = yi_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          xr_d     = c[N-1:W];
          xi_d     = c[W-1:0];
          yr_d     = d[N-1:W];
          yi_d     = d[W-1:0];
          op_d     = control;
          cnt_d    = 2'd0;
          acc_re_d = '0;
          acc_im_d = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        case (op_q)
          OP_ADD: begin
            acc_re_d = xr_ext + yr_ext;
            acc_im_d = xi_ext + yi_ext;
          end
          OP_SUB: begin
            acc_re_d = xr_ext - yr_ext;
            acc_im_d = xi_ext - yi_ext;
          end
          OP_MUL: begin
            case (cnt_q)
              2'd0:    acc_re_d = prod_ext;
              2'd1:    acc_re_d = acc_re_q - prod_ext;
              2'd2:    acc_im_d = prod_ext;
              default: acc_im_d = acc_im_q + prod_ext;
            endcase
          end
          default: begin
            acc_re_d = (cnt_q == 2'd0) ? prod_ext : acc_re_q + prod_ext;
            acc_im_d = '0;
          end
        endcase
        // On the last cycle the freshly accumulated value is the final one.
        if (cnt_q == k_last) begin
          result_d = {acc_re_d[W-1:0], acc_im_d[W-1:0]};
          ovf_d    = out_of_range(acc_re_d) || out_of_range(acc_im_d);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      xr_q     <= '0;
      xi_q     <= '0;
      yr_q     <= '0;
      yi_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      xr_q     <= xr_d;
      xi_q     <= xi_d;
      yr_q     <= yr_d;
      yi_q     <= yi_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      alive_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_complex_alu_seq.sv
// Scoreboard bench for complex_alu_seq: a driver pushes model results, a
// monitor pops and compares them whenever the DUT presents an output.
module tb_complex_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] c, d;
  logic [1:0]  control;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    int          k;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   cycle    = 0;
  int   last_acc = 0;
  bit   seen     = 1'b0;
  bit   bp_en    = 1'b0;

  complex_alu_seq #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c),
    .d         (d),
    .control   (control),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the signed halves.
  function automatic void model(input logic [31:0] cv, input logic [31:0] dv, input logic [1:0] op,
                                output logic [31:0] res, output logic ov, output int k);
    longint xr, xi, yr, yi, re, im;
    xr = longint'($signed(cv[31:16]));
    xi = longint'($signed(cv[15:0]));
    yr = longint'($signed(dv[31:16]));
    yi = longint'($signed(dv[15:0]));
    case (op)
      2'b00:   begin re = xr + yr;           im = xi + yi;           k = 1; end
      2'b01:   begin re = xr - yr;           im = xi - yi;           k = 1; end
      2'b10:   begin re = xr * yr - xi * yi; im = xr * yi + xi * yr; k = 4; end
      default: begin re = xr * xr + xi * xi; im = 0;                 k = 2; end
    endcase
    res = {re[15:0], im[15:0]};
    ov  = (re < -32768) || (re > 32767) || (im < -32768) || (im > 32767);
  endfunction

  function automatic logic [15:0] rand_half();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [31:0] cv, input logic [31:0] dv, input logic [1:0] op);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    c = cv; d = dv; control = op; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    model(cv, dv, op, e.res, e.ov, e.k);
    e.acc_cyc = cycle + 1;
    last_acc  = e.acc_cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c = $urandom; d = $urandom; control = 2'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && in_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!(sb.size() == 0 && in_ready)) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: first sighting of each output is compared against the queue head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("ovf", 64'(ovf), 64'(e.ov));
        check("latency", 64'(cycle - e.acc_cyc), 64'(e.k));
      end
    end
    if (out_valid && out_ready) seen = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [31:0] r0;
    logic        o0;
    int          acc_a;
    int          guard;

    rst_n = 1'b0; c = '0; d = '0; control = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 64'(in_ready), 64'd1);

    issue({16'd3, 16'd4}, {16'd1, 16'hFFFE}, 2'b00);
    issue({16'd3, 16'd4}, {16'd1, 16'd2}, 2'b10);
    issue({16'd3, 16'd4}, $urandom, 2'b11);
    issue({16'd32767, 16'd0}, {16'd1, 16'd0}, 2'b00);
    issue({16'd5, 16'hFFFD}, {16'd7, 16'd4}, 2'b01);
    issue({16'h8000, 16'h8000}, {16'h8000, 16'h7FFF}, 2'b10);
    drain();

    // Back-to-back throughput with out_ready held high.
    issue({16'd1, 16'd2}, {16'd3, 16'd4}, 2'b00);
    acc_a = last_acc;
    issue({16'd5, 16'd6}, {16'd7, 16'd8}, 2'b01);
    check("throughput_gap", 64'(last_acc - acc_a), 64'd3);
    drain();

    // Idle input changes must not disturb the held result.
    r0 = result;
    o0 = ovf;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c = $urandom; d = $urandom; control = 2'($urandom);
      check("idle_result_hold", 64'(result), 64'(r0));
      check("idle_out_valid", 64'(out_valid), 64'd0);
    end

    // Backpressure: hold the output, ignore new requests.
    @(negedge clk);
    out_ready = 1'b0;
    issue({16'h7FFF, 16'd0}, {16'd1, 16'd0}, 2'b00);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    r0 = result;
    o0 = ovf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 64'(result), 64'h8000_0000);
      check("bp_ovf", 64'(ovf), 64'd1);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      c = $urandom; d = $urandom; control = 2'($urandom); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_stable_held", 64'({r0, o0}), 64'({32'h8000_0000, 1'b1}));

    // Reset in the second CALC cycle of a multiply.
    issue({16'd3, 16'd4}, {16'd1, 16'd2}, 2'b10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    issue({16'd1, 16'd1}, {16'd1, 16'd1}, 2'b00);
    drain();

    // Randomized traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue({rand_half(), rand_half()}, {rand_half(), rand_half()}, 2'($urandom));
    end
    bp_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/complex_alu_seq.md
COMPLEX_ALU_SEQ -- requirements
Module: complex_alu_seq

Interface
REQ-001 Parameter N, default 32, SHALL set total operand/result width; even, >= 8; each half is W = N/2 bits, two's complement.
REQ-002 Operand/result packing SHALL be {real[N-1:W], imag[W-1:0]}.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 c  input  N  SHALL carry operand X = {xr, xi}.
REQ-006 d  input  N  SHALL carry operand Y = {yr, yi}.
REQ-007 control  input  2  SHALL select op: 00 add, 01 sub, 10 complex multiply, 11 magnitude-squared of X.
REQ-008 in_valid  input  1  SHALL mark c, d and control as valid.
REQ-009 in_ready  output  1  SHALL indicate that an operation can be accepted.
REQ-010 result  output  N  SHALL carry the packed result, registered.
REQ-011 ovf  output  1  SHALL flag that a result half was wrapped.
REQ-012 out_valid  output  1  SHALL mark result and ovf as valid.
REQ-013 out_ready  input  1  SHALL indicate that the consumer takes the result.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Acceptance SHALL occur on an edge with in_valid & in_ready; c, d and control are captured; IDLE -> CALC.
REQ-016 CALC SHALL last K cycles: K=1 for add/sub, K=4 for mul, K=2 for mag; the cycle counter is cleared on acceptance.
REQ-017 The result SHALL be registered and out_valid set on the K-th edge after the acceptance edge; CALC -> DONE.
REQ-018 Add SHALL give {xr+yr, xi+yi}; sub SHALL give {xr-yr, xi-yi}.
REQ-019 Mul SHALL give {xr*yr - xi*yi, xr*yi + xi*yr}, computed with one shared W x W signed multiplier, one product per CALC cycle, in the order xr*yr, xi*yi, xr*yi, xi*yr, accumulated at 2W+2 bits.
REQ-020 Mag SHALL give {xr*xr + xi*xi, 0}, with products in the order xr*xr, xi*xi; d is ignored.
REQ-021 Each result half SHALL be the low W bits of the full-precision value (wrap-around, no saturation).
REQ-022 ovf SHALL be 1 iff either full-precision half lies outside [-2^(W-1), 2^(W-1)-1]; ovf is 0 for the imaginary half of mag.
REQ-023 In DONE, result, ovf and out_valid SHALL hold stable until out_valid & out_ready; on that edge DONE -> IDLE, out_valid -> 0, and in_ready = 1 from the next cycle.
REQ-024 No new acceptance SHALL occur in CALC or DONE, so back-to-back throughput is one op per K+2 cycles with out_ready held at 1.
REQ-025 In IDLE, changes on c, d and control SHALL NOT affect the outputs; result and ovf keep their last values.
REQ-026 Operands captured at acceptance SHALL be used for the whole CALC, regardless of later input changes.
REQ-027 in_valid in non-IDLE states SHALL be ignored; the requester must hold it until in_ready.
REQ-028 The FSM SHALL have no unreachable lock-up; any illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-029 On rst_n = 0, asynchronously: state = IDLE, result = 0, ovf = 0, out_valid = 0, cycle counter = 0, accumulators = 0.
REQ-030 in_ready SHALL be 0 while rst_n = 0 and 1 on the first edge after release.
REQ-031 Reset during CALC or DONE SHALL abort the operation with no stale out_valid after release.

Verification (N=32, W=16)
REQ-032 add: c={3,4}, d={1,-2}, control=00 -> result {4,2}, ovf=0, out_valid 1 edge after acceptance.
REQ-033 mul: c={3,4}, d={1,2}, control=10 -> result {-5,10}, ovf=0, out_valid exactly 4 edges after acceptance.
REQ-034 mag: c={3,4}, control=11, d=random -> result {25,0}, out_valid 2 edges after acceptance; overflow case c={32767,0}, d={1,0}, control=00 -> result {-32768,0}, ovf=1.
REQ-035 backpressure: out_ready=0 for 5 cycles after out_valid -> result, ovf and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> handshake completes, then in_ready=1 the next cycle.
REQ-036 reset mid-mul: rst_n low in the 2nd CALC cycle -> all outputs 0 immediately; after release in_ready=1; a fresh add of {1,1}+{1,1} -> {2,2}.
